// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the jtkcpu bus scheduler: ROM fetch FSM encodings and abort data.
package jtkcpu_pkg;

    typedef enum logic {
        ROM_IDLE = 1'b0,
        ROM_WAIT = 1'b1
    } rom_state_t;

    // Value returned to the core when a ROM fetch is abandoned by the watchdog
    localparam logic [7:0] ROM_ABORT_DATA = 8'hFF;

endpackage

// File: rtl/jtkcpu_cendiv.sv
// Fractional clock-enable divider: o_cen pulses at clk*CENNUM/CENDEN using a phase accumulator.
module jtkcpu_cendiv #(
    parameter int CENNUM = 1,
    parameter int CENDEN = 4
)(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_cen
);
    // acc stays below CENDEN, so acc+CENNUM is always below 2*CENDEN
    localparam int AW = $clog2(2 * CENDEN);

    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_sum;
    logic          r_cen;

    assign w_sum = r_acc + AW'(CENNUM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_cen <= 1'b0;
        end else if (w_sum >= AW'(CENDEN)) begin
            r_acc <= w_sum - AW'(CENDEN);
            r_cen <= 1'b1;
        end else begin
            r_acc <= w_sum;
            r_cen <= 1'b0;
        end
    end

    assign o_cen = r_cen;

endmodule

// File: rtl/jtkcpu_busctl.sv
// Bus scheduler for the jtkcpu core: cen2 generation, ROM wait states, work RAM CPU/DMA arbitration.
// Optional ROM watchdog enabled by defining JTKCPU_BUSCTL_WDOG_EN.
module jtkcpu_busctl
    import jtkcpu_pkg::*;
#(
    parameter int CENNUM = 1,
    parameter int CENDEN = 4,
    parameter int RAMW   = 13,
    parameter int TOUT   = 255
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [23:0]     i_cpu_addr,
    input  logic            i_cpu_we,
    input  logic [7:0]      i_cpu_dout,
    input  logic            i_rom_cs,
    input  logic            i_ram_cs,
    output logic            o_cen2,
    output logic            o_dtack,
    output logic [7:0]      o_cpu_din,
    output logic [23:0]     o_rom_addr,
    output logic            o_rom_req,
    input  logic            i_rom_ok,
    input  logic [7:0]      i_rom_data,
    input  logic            i_dma_req,
    output logic            o_dma_gnt,
    input  logic [RAMW-1:0] i_dma_addr,
    input  logic            i_dma_we,
    input  logic [7:0]      i_dma_dout,
    output logic [RAMW-1:0] o_ram_addr,
    output logic            o_ram_we,
    output logic [7:0]      o_ram_din,
    input  logic [7:0]      i_ram_q,
    output logic            o_bus_tout,
    output rom_state_t      o_dbg_state
);
    // Handshakes: rom_req is a level held until rom_ok is accepted (ok in the first WAIT cycle is
    // stale and dropped); dma_gnt follows dma_req one clk later unless the CPU holds ram_cs.
    rom_state_t  r_state,    w_state;
    logic [23:0] r_rom_addr, w_rom_addr;
    logic        r_rom_req,  w_rom_req;
    logic        r_rom_vld,  w_rom_vld;
    logic        r_guard,    w_guard;
    logic [7:0]  r_latch,    w_latch;
    logic        r_bus_tout, w_bus_tout;
    logic        r_dma_gnt,  w_dma_gnt;
    logic        w_hit;
    logic        w_cen2;
`ifdef JTKCPU_BUSCTL_WDOG_EN
    localparam logic [7:0] TOUT_V = 8'(TOUT);
    logic [7:0]  r_wcnt, w_wcnt;
    logic [7:0]  w_wcnt_inc;
    assign w_wcnt_inc = r_wcnt + 8'd1;
`endif

    jtkcpu_cendiv #(
        .CENNUM (CENNUM),
        .CENDEN (CENDEN)
    ) u_cendiv (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_cen  (w_cen2)
    );

    assign w_hit = r_rom_vld && (r_rom_addr == i_cpu_addr);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ROM_IDLE;
            r_rom_addr <= '0;
            r_rom_req  <= 1'b0;
            r_rom_vld  <= 1'b0;
            r_guard    <= 1'b0;
            r_latch    <= '0;
            r_bus_tout <= 1'b0;
            r_dma_gnt  <= 1'b0;
`ifdef JTKCPU_BUSCTL_WDOG_EN
            r_wcnt     <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_rom_addr <= w_rom_addr;
            r_rom_req  <= w_rom_req;
            r_rom_vld  <= w_rom_vld;
            r_guard    <= w_guard;
            r_latch    <= w_latch;
            r_bus_tout <= w_bus_tout;
            r_dma_gnt  <= w_dma_gnt;
`ifdef JTKCPU_BUSCTL_WDOG_EN
            r_wcnt     <= w_wcnt;
`endif
        end
    end

    always_comb begin
        w_state    = r_state;
        w_rom_addr = r_rom_addr;
        w_rom_req  = r_rom_req;
        w_rom_vld  = r_rom_vld;
        w_guard    = r_guard;
        w_latch    = r_latch;
        w_bus_tout = 1'b0;
`ifdef JTKCPU_BUSCTL_WDOG_EN
        w_wcnt     = r_wcnt;
`endif
        // The CPU always wins a tie; DMA keeps the port for as long as it asks
        w_dma_gnt  = r_dma_gnt ? i_dma_req : (i_dma_req && !i_ram_cs);
        case (r_state)
            ROM_IDLE: begin
                if (i_rom_cs && !w_hit) begin
                    w_rom_addr = i_cpu_addr;
                    w_rom_req  = 1'b1;
                    w_rom_vld  = 1'b0;
                    w_guard    = 1'b1;
                    w_state    = ROM_WAIT;
                end
            end
            ROM_WAIT: begin
                if (i_rom_cs && (i_cpu_addr != r_rom_addr)) begin
                    w_rom_addr = i_cpu_addr;
                    w_guard    = 1'b1;
`ifdef JTKCPU_BUSCTL_WDOG_EN
                    w_wcnt     = '0;
`endif
                end else if (r_guard) begin
                    w_guard = 1'b0;
                end else if (i_rom_ok) begin
                    w_latch   = i_rom_data;
                    w_rom_vld = 1'b1;
                    w_rom_req = 1'b0;
                    w_state   = ROM_IDLE;
`ifdef JTKCPU_BUSCTL_WDOG_EN
                    w_wcnt    = '0;
                end else if (w_wcnt_inc == TOUT_V) begin
                    w_latch    = ROM_ABORT_DATA;
                    w_rom_vld  = 1'b1;
                    w_rom_req  = 1'b0;
                    w_bus_tout = 1'b1;
                    w_wcnt     = '0;
                    w_state    = ROM_IDLE;
                end else begin
                    w_wcnt = w_wcnt_inc;
`endif
                end
            end
            default: w_state = ROM_IDLE;
        endcase
    end

    always_comb begin
        o_dtack    = !(i_rom_cs && !w_hit) && !(i_ram_cs && r_dma_gnt);
        o_cpu_din  = i_rom_cs ? r_latch : i_ram_q;
        o_ram_addr = r_dma_gnt ? i_dma_addr : i_cpu_addr[RAMW-1:0];
        o_ram_din  = r_dma_gnt ? i_dma_dout : i_cpu_dout;
        o_ram_we   = r_dma_gnt ? i_dma_we : (i_cpu_we && i_ram_cs && w_cen2);
    end

    assign o_cen2      = w_cen2;
    assign o_rom_addr  = r_rom_addr;
    assign o_rom_req   = r_rom_req;
    assign o_dma_gnt   = r_dma_gnt;
    assign o_dbg_state = r_state;
`ifdef JTKCPU_BUSCTL_WDOG_EN
    assign o_bus_tout  = r_bus_tout;
`else
    // No watchdog: a fetch only ends on rom_ok, so bus_tout never fires (TOUT < 0 is always false)
    assign o_bus_tout  = r_bus_tout | (TOUT < 0);
`endif

endmodule
